multi_word_add_ctrl: RTL and testbench

- Sequencer that time-shares one WIDTH-bit adder slice to perform WIDTH*WORDS-bit additions.
- Processes one slice per clock, least-significant first, with the carry registered between cycles.
- Sits between a requester (valid/ready request channel) and a consumer (valid/ready response channel).
- Gives multi-precision sums at slice-level area cost, in place of a wide ripple chain.

---
 rtl/multi_word_add_pkg.sv | 18 +
 rtl/slice_adder.sv | 15 +
 rtl/multi_word_add_ctrl.sv | 132 +++++++++++++
 tb/tb_multi_word_add_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multi_word_add_pkg.sv
// Shared types and constants for the multi-word add sequencer.
package multi_word_add_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the slice index counter; at least one bit even for a single word.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational WIDTH-bit adder slice: {cout, sum} = a + b + cin.
module slice_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cout,
  output logic [WIDTH-1:0] sum
);

  // Single ripple slice with the carry-out as the extra top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);

endmodule

// File: rtl/multi_word_add_ctrl.sv
// Multi-word adder sequencer: one WIDTH-bit slice per clock, LSB slice first,
// carry held in a register between slices.
// Optional macro ADD_SUB_EN adds a 'sub' input selecting A-B.
module multi_word_add_ctrl
  import multi_word_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef ADD_SUB_EN
  input  logic                   sub,
`endif
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int unsigned N  = WIDTH * WORDS;
  localparam int unsigned IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t            state_q, state_d;
  logic [N-1:0]      a_q, b_q;
  logic [IW-1:0]     idx_q;
  logic              carry_q;
  logic              accept_c;
  logic [WIDTH-1:0]  a_slice_c, b_slice_c, s_slice_c;
  logic              co_slice_c;
  logic              cin_first_c;
`ifdef ADD_SUB_EN
  logic              sub_q;
`endif

  // Current operand slices; subtraction inverts B slice by slice.
  always_comb begin
    a_slice_c = a_q[idx_q*WIDTH +: WIDTH];
    b_slice_c = b_q[idx_q*WIDTH +: WIDTH];
`ifdef ADD_SUB_EN
    if (sub_q) b_slice_c = ~b_slice_c;
`endif
  end

  // Carry into slice 0 at capture time; subtraction forces it to 1.
  always_comb begin
    cin_first_c = cin;
`ifdef ADD_SUB_EN
    cin_first_c = cin | sub;
`endif
  end

  slice_adder #(.WIDTH(WIDTH)) u_slice (
    .cin  (carry_q),
    .a    (a_slice_c),
    .b    (b_slice_c),
    .cout (co_slice_c),
    .sum  (s_slice_c)
  );

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Operand capture, slice index, carry chain and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= b;
      idx_q   <= '0;
      carry_q <= cin_first_c;
`ifdef ADD_SUB_EN
      sub_q   <= sub;
`endif
    end else if (state_q == ST_RUN) begin
      sum[idx_q*WIDTH +: WIDTH] <= s_slice_c;
      carry_q <= co_slice_c;
      idx_q   <= idx_q + IW'(1);
      if (idx_q == LAST_IDX) cout <= co_slice_c;
    end
  end

endmodule

// File: tb/tb_multi_word_add_ctrl.sv
// Self-checking bench for multi_word_add_ctrl against a plain-arithmetic model.
module tb_multi_word_add_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [N-1:0] a, b, sum;
  logic         cin, cout;
  logic         rsp_valid, rsp_ready, busy;
`ifdef ADD_SUB_EN
  logic         sub;
`endif

  int total = 0;
  int bad   = 0;

  multi_word_add_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ADD_SUB_EN
    .sub       (sub),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned N-bit add (or A + ~B + 1 for subtract) with true carry-out.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic c, input logic s);
    logic [N:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (N+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + (N+1)'(c);
    return r;
  endfunction

  // One full transaction: accept, scramble inputs during RUN/DONE, hold the
  // response for 'hold' cycles, then release and confirm return to idle.
  task automatic run_txn(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xc,
                         input logic xs, input int hold);
    logic [N:0] exp;
    logic [N-1:0] held;
    int lat;
    exp = model(xa, xb, xc, xs);
    @(negedge clk);
    a = xa; b = xb; cin = xc; req_valid = 1'b1;
`ifdef ADD_SUB_EN
    sub = xs;
`endif
    #1;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    // Inputs changed after accept must not matter; req_valid is ignored while busy.
    a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
`ifdef ADD_SUB_EN
    sub = 1'($urandom);
`endif
    check("busy_run", 64'({busy, req_ready}), 64'b10);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(WORDS));
    if (lat >= 50) return;
    check("sum", 64'(sum), 64'(exp[N-1:0]));
    check("cout", 64'(cout), 64'(exp[N]));
    held = sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      a = N'($urandom); b = N'($urandom);
      check("hold_state", 64'({rsp_valid, req_ready, busy}), 64'b101);
      check("hold_sum", 64'(sum), 64'(held));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("release", 64'({rsp_valid, req_ready, busy}), 64'b010);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [N:0] exp;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef ADD_SUB_EN
    sub = 1'b0;
`endif
    #23;
    check("rst_flags", 64'({req_ready, rsp_valid, busy}), 64'b100);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // rsp_ready while idle is ignored.
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_rsp_ready", 64'({req_ready, rsp_valid, busy}), 64'b100);
    rsp_ready = 1'b0;

    run_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
    run_txn(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 5);
    run_txn(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);

    // Reset while two slices are done: everything returns to reset values at once.
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_flags", 64'({req_ready, rsp_valid, busy}), 64'b100);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < WORDS + 2; i++) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    run_txn(32'd5, 32'd3, 1'b0, 1'b0, 0);

`ifdef ADD_SUB_EN
    run_txn(32'd5, 32'd7, 1'b0, 1'b1, 0);
    run_txn(32'd7, 32'd5, 1'b0, 1'b1, 1);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = (k % 4 == 0) ? ~ra : N'($urandom);
`ifdef ADD_SUB_EN
      run_txn(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
`else
      run_txn(ra, rb, 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
`endif
    end

    exp = model(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("model_sanity", 64'(exp), 64'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
